cfg_stream_tx: RTL and testbench
================================

Name: cfg_stream_tx

Overview:
- Serial configuration transmitter: the driving end of the `config_in` bitstream consumed by the fabric top.
- Accepts parallel configuration words over a valid/ready handshake and serializes them MSB-first onto `cfg_data`, qualified by `cfg_shift_en`.
- Sits between the config loader (host/ROM side) and the fabric's serial config chain; one instance drives one chain of `NUM_WORDS*WORD_W` bits.

Parameters:
- `WORD_W`, 8: width of each parallel configuration word, in bits; must be ≥ 2.
- `NUM_WORDS`, 8: number of words making up one complete chain load; must be ≥ 1.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-low reset (0 = reset).
- `start`  input  1  one-cycle request to begin a full chain load; sampled only in IDLE.
- `word_in`  input  `WORD_W`  configuration word; bit `WORD_W-1` is sent first.
- `word_valid`  input  1  `word_in` is valid.
- `word_ready`  output  1  block accepts `word_in` this cycle.
- `cfg_data`  output  1  serial config bit; connects to the fabric `config_in`.
- `cfg_shift_en`  output  1  `cfg_data` is a real chain bit this cycle.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when the last bit of the chain has been sent.

Behaviour:
- Reset values, with `rst`=0 at a clock edge: state=IDLE, `word_ready`=0, `cfg_data`=0, `cfg_shift_en`=0, `busy`=0, `done`=0; shift register, bit counter and word counter all cleared.
- All outputs are registered, except `word_ready`, which is decoded directly from state (state==LOAD).
- FSM states: IDLE, LOAD, SHIFT, FIN.
- IDLE:
  - `start`=1 -> LOAD; word counter cleared.
  - `word_valid` is ignored in IDLE.
- LOAD:
  - `word_ready`=1, `cfg_shift_en`=0, `cfg_data`=0.
  - Stays in LOAD while `word_valid`=0 (stall; no timeout).
  - On `word_valid`&&`word_ready`: capture `word_in` into the shift register, bit counter=0, go to SHIFT.
- SHIFT:
  - The cycle after acceptance presents bit `WORD_W-1` on `cfg_data` with `cfg_shift_en`=1.
  - Each following cycle presents the next lower bit.
  - Exactly `WORD_W` consecutive cycles with `cfg_shift_en`=1 per word.
  - After the bit-0 cycle, increment the word counter.
  - If the word counter reaches `NUM_WORDS` -> FIN; otherwise -> LOAD.
- Per-word cost: minimum `WORD_W`+1 cycles (one LOAD cycle plus `WORD_W` shift cycles). There is always at least one cycle with `cfg_shift_en`=0 between words.
- FIN: `done`=1 for exactly one cycle, `cfg_shift_en`=0, `cfg_data`=0; next state IDLE.
- `start` asserted outside IDLE: ignored; it is not queued.
- `start` in the same cycle as FIN: ignored; the block must return to IDLE first.
- Reset mid-operation: immediate abort to IDLE on that edge. Partial chain contents are not the block's responsibility; the loader must restart.
- `cfg_data` is held at 0 whenever `cfg_shift_en`=0.
- Counter widths:
  - bit counter: `$clog2(WORD_W)`.
  - word counter: `$clog2(NUM_WORDS+1)`.
  - No wrap-around is permitted within one load.
- Total shift cycles per load is exactly `NUM_WORDS*WORD_W` (without the optional feature).

Optional Feature:
- Macro: `CFG_TX_PARITY_EN`.
- Defined:
  - After bit 0 of each word, one extra SHIFT cycle with `cfg_shift_en`=1 carries the even-parity bit of that word (XOR of all `WORD_W` bits).
  - Each word therefore takes `WORD_W`+1 shift cycles; total shift cycles per load is `NUM_WORDS*(WORD_W+1)`.
  - The bit counter widens to `$clog2(WORD_W+1)`.
- Undefined: no parity cycle; the logic is absent from the netlist.

Test Plan:
- Default parameters, reset, then `start` with `word_valid` held high and words 0xA5,0x01,…,0x07 -> `cfg_data` stream begins 1,0,1,0,0,1,0,1; exactly 64 cycles with `cfg_shift_en`=1; a single `cfg_shift_en`=0 gap between words; `done` pulses once; `busy` falls on the cycle after `done`.
- Stall: `word_valid` low for 5 cycles in LOAD after the third word -> `word_ready` stays 1 and `cfg_shift_en` stays 0 for those 5 cycles; the stream then resumes with the correct next word.
- `start` pulsed during SHIFT and again on the FIN cycle -> no effect; exactly one `done`; the block returns to IDLE.
- `rst`=0 asserted mid-way through word 4 -> on the next edge all outputs are 0 and state is IDLE; a subsequent `start` yields a full clean 64-bit load.
- `WORD_W`=4, `NUM_WORDS`=1, word 0xC -> `cfg_data` 1,1,0,0 with `cfg_shift_en`=1; `done` on the cycle after the last bit.
- With `CFG_TX_PARITY_EN`, word 0xA5 (four ones) -> 9 shift cycles, 9th bit=0; word 0x07 -> 9th bit=1; total 72 shift cycles per default load.

Source files
------------

// File: rtl/cfg_stream_tx_if.sv
// Parallel configuration word handshake between the config loader and cfg_stream_tx.
interface cfg_stream_tx_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/cfg_stream_tx.sv
// Serial configuration transmitter: serializes NUM_WORDS parallel words MSB-first onto cfg_data.
// Optional macro CFG_TX_PARITY_EN appends an even-parity bit after bit 0 of every word.
module cfg_stream_tx #(
  parameter int WORD_W    = 8,
  parameter int NUM_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  cfg_stream_tx_if.slave       word_bus,
  output logic                 cfg_data,
  output logic                 cfg_shift_en,
  output logic                 busy,
  output logic                 done
);

`ifdef CFG_TX_PARITY_EN
  localparam int BIT_CW   = $clog2(WORD_W + 1);
  localparam int LAST_BIT = WORD_W;
`else
  localparam int BIT_CW   = $clog2(WORD_W);
  localparam int LAST_BIT = WORD_W - 1;
`endif
  localparam int WORD_CW = $clog2(NUM_WORDS + 1);

  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(LAST_BIT);
  localparam logic [WORD_CW-1:0] WORD_LAST = WORD_CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic [WORD_W-1:0]   sreg_q;
  logic [BIT_CW-1:0]   bit_cnt_q;
  logic [WORD_CW-1:0]  word_cnt_q;
  logic                bit_last;
  logic                word_last;
  logic                accept;
  logic                data_d;
  logic                shift_en_d;
  logic                busy_d;
  logic                done_d;

`ifdef CFG_TX_PARITY_EN
  localparam logic [BIT_CW-1:0] BIT_PAR_PREV = BIT_CW'(WORD_W - 1);

  logic par_q;

  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction
`endif

  assign word_bus.word_ready = (state_q == LOAD);
  assign accept              = (state_q == LOAD) && word_bus.word_valid;
  assign bit_last            = (bit_cnt_q == BIT_LAST);
  assign word_last           = (word_cnt_q == WORD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (word_bus.word_valid) state_nxt = SHIFT;
      SHIFT:   if (bit_last) state_nxt = word_last ? FIN : LOAD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: values computed here become visible on the following cycle.
  always_comb begin
    data_d     = 1'b0;
    shift_en_d = 1'b0;
    busy_d     = (state_nxt != IDLE);
    done_d     = (state_nxt == FIN);
    case (state_q)
      LOAD: begin
        if (word_bus.word_valid) begin
          shift_en_d = 1'b1;
          data_d     = word_bus.word_in[WORD_W-1];
        end
      end
      SHIFT: begin
        if (!bit_last) begin
          shift_en_d = 1'b1;
`ifdef CFG_TX_PARITY_EN
          data_d     = (bit_cnt_q == BIT_PAR_PREV) ? par_q : sreg_q[WORD_W-2];
`else
          data_d     = sreg_q[WORD_W-2];
`endif
        end
      end
      default: begin
        data_d     = 1'b0;
        shift_en_d = 1'b0;
      end
    endcase
  end

  // sreg_q[WORD_W-1] always holds the bit currently presented on cfg_data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      cfg_data     <= 1'b0;
      cfg_shift_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef CFG_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      cfg_data     <= data_d;
      cfg_shift_en <= shift_en_d;
      busy         <= busy_d;
      done         <= done_d;
      case (state_q)
        IDLE: begin
          if (start) word_cnt_q <= '0;
        end
        LOAD: begin
          if (accept) begin
            sreg_q    <= word_bus.word_in;
            bit_cnt_q <= '0;
`ifdef CFG_TX_PARITY_EN
            par_q     <= even_parity(word_bus.word_in);
`endif
          end
        end
        SHIFT: begin
          if (bit_last) begin
            word_cnt_q <= word_cnt_q + 1'b1;
          end else begin
            sreg_q    <= {sreg_q[WORD_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: begin
          sreg_q <= sreg_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_stream_tx.sv
// Directed bench for cfg_stream_tx: a default 8x8 instance and a 4-bit single-word instance.
module tb_cfg_stream_tx;

`ifdef CFG_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NW  = 8;
  localparam int BPW = 8 + PAR;

  logic clk;
  logic rst_m, rst_s;
  logic start, s_start;
  logic cfg_data, cfg_shift_en, busy, done;
  logic s_data, s_en, s_busy, s_done;

  int checks = 0;
  int errors = 0;

  cfg_stream_tx_if #(.WORD_W(8)) m_bus ();
  cfg_stream_tx_if #(.WORD_W(4)) s_bus ();

  cfg_stream_tx #(.WORD_W(8), .NUM_WORDS(NW)) dut_m (
    .clk          (clk),
    .rst          (rst_m),
    .start        (start),
    .word_bus     (m_bus),
    .cfg_data     (cfg_data),
    .cfg_shift_en (cfg_shift_en),
    .busy         (busy),
    .done         (done)
  );

  cfg_stream_tx #(.WORD_W(4), .NUM_WORDS(1)) dut_s (
    .clk          (clk),
    .rst          (rst_s),
    .start        (s_start),
    .word_bus     (s_bus),
    .cfg_data     (s_data),
    .cfg_shift_en (s_en),
    .busy         (s_busy),
    .done         (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word and its expected serial image: 8 data bits MSB-first then the even-parity bit.
  typedef struct {
    logic [7:0] word;
    logic [8:0] exp_bits;
  } word_vec_t;

  // One cycle: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic       rst;
    logic       start;
    logic       valid;
    logic [3:0] word;
    logic       ready;
    logic       data;
    logic       en;
    logic       busy;
    logic       done;
  } cyc_vec_t;

  word_vec_t tbl [NW];
  cyc_vec_t  sv [$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_load(input int stall_len, input bit poke_start);
    logic exp_q [$];
    int   accepted   = 0;
    int   shifts     = 0;
    int   run_len    = 0;
    int   runs       = 0;
    int   gap        = 0;
    int   dones      = 0;
    int   stall      = 0;
    int   after_done = -1;
    bit   prev_en    = 1'b0;
    bit   poked      = 1'b0;
    bit   finished   = 1'b0;
    for (int w = 0; w < NW; w++) begin
      for (int b = 8; b >= 1; b--) exp_q.push_back(tbl[w].exp_bits[b]);
      if (PAR != 0) exp_q.push_back(tbl[w].exp_bits[0]);
    end
    @(negedge clk);
    start            = 1'b1;
    m_bus.word_valid = 1'b1;
    m_bus.word_in    = tbl[0].word;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cfg_shift_en) begin
        if (!prev_en && runs > 0)
          chkn("gap_len", gap, (runs == 3 && stall_len > 0) ? 1 + stall_len : 1);
        if (exp_q.size() > 0) chk1("stream_bit", cfg_data, exp_q.pop_front());
        else chk1("extra_shift", cfg_shift_en, 1'b0);
        shifts++;
        run_len++;
        gap = 0;
      end else begin
        chk1("idle_data_zero", cfg_data, 1'b0);
        if (prev_en) begin
          chkn("word_len", run_len, BPW);
          runs++;
          run_len = 0;
        end
        gap++;
      end
      if (done) begin
        dones++;
        chk1("done_after_last_bit", prev_en, 1'b1);
        chk1("busy_on_done", busy, 1'b1);
        chkn("words_before_done", runs, NW);
        after_done = 0;
        if (poke_start) start = 1'b1;
      end else if (after_done >= 0) begin
        after_done++;
        chk1("busy_after_done", busy, 1'b0);
        chk1("ready_after_done", m_bus.word_ready, 1'b0);
        if (after_done == 2) finished = 1'b1;
      end else begin
        chk1("busy_during_load", busy, 1'b1);
      end
      if (poke_start && !poked && shifts == 10) begin
        start = 1'b1;
        poked = 1'b1;
      end
      prev_en          = cfg_shift_en;
      m_bus.word_valid = 1'b1;
      if (m_bus.word_ready) begin
        chk1("load_no_shift", cfg_shift_en, 1'b0);
        if (accepted == 3 && stall < stall_len) begin
          m_bus.word_valid = 1'b0;
          stall++;
        end
        if (accepted < NW) m_bus.word_in = tbl[accepted].word;
        if (m_bus.word_valid) accepted++;
      end
    end
    chk1("load_finished", finished, 1'b1);
    chkn("shift_total", shifts, NW * BPW);
    chkn("done_count", dones, 1);
    chkn("words_accepted", accepted, NW);
    chkn("stall_cycles", stall, stall_len);
    chkn("bits_left", exp_q.size(), 0);
  endtask

  initial begin
    int acc;
    int sh;

    tbl[0] = '{8'hA5, {8'hA5, 1'b0}};
    tbl[1] = '{8'h01, {8'h01, 1'b1}};
    tbl[2] = '{8'h02, {8'h02, 1'b1}};
    tbl[3] = '{8'h03, {8'h03, 1'b0}};
    tbl[4] = '{8'h04, {8'h04, 1'b1}};
    tbl[5] = '{8'h05, {8'h05, 1'b0}};
    tbl[6] = '{8'h06, {8'h06, 1'b0}};
    tbl[7] = '{8'h07, {8'h07, 1'b1}};

    //                rst   start valid word   ready data  en    busy  done
    sv.push_back('{1'b0, 1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    sv.push_back('{1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    sv.push_back('{1'b1, 1'b1, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    sv.push_back('{1'b1, 1'b0, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    sv.push_back('{1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    sv.push_back('{1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    sv.push_back('{1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    sv.push_back('{1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    if (PAR != 0)
      sv.push_back('{1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    sv.push_back('{1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    sv.push_back('{1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    sv.push_back('{1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    rst_m = 1'b0;
    rst_s = 1'b0;
    start = 1'b0;
    s_start = 1'b0;
    m_bus.word_valid = 1'b0;
    m_bus.word_in    = '0;
    s_bus.word_valid = 1'b0;
    s_bus.word_in    = '0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_cfg_data", cfg_data, 1'b0);
    chk1("rst_shift_en", cfg_shift_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ready", m_bus.word_ready, 1'b0);
    rst_m = 1'b1;

    for (int i = 0; i < sv.size(); i++) begin
      rst_s            = sv[i].rst;
      s_start          = sv[i].start;
      s_bus.word_valid = sv[i].valid;
      s_bus.word_in    = sv[i].word;
      @(negedge clk);
      chk1($sformatf("small_ready[%0d]", i), s_bus.word_ready, sv[i].ready);
      chk1($sformatf("small_data[%0d]", i), s_data, sv[i].data);
      chk1($sformatf("small_en[%0d]", i), s_en, sv[i].en);
      chk1($sformatf("small_busy[%0d]", i), s_busy, sv[i].busy);
      chk1($sformatf("small_done[%0d]", i), s_done, sv[i].done);
    end
    s_start = 1'b0;

    run_load(0, 1'b0);
    run_load(5, 1'b1);

    // Abort in the middle of the fourth word, then reload from scratch.
    @(negedge clk);
    start            = 1'b1;
    m_bus.word_valid = 1'b1;
    m_bus.word_in    = tbl[0].word;
    acc = 0;
    sh  = 0;
    for (int c = 0; c < 200 && sh < 3 * BPW + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (cfg_shift_en) sh++;
      if (m_bus.word_ready && acc < NW) begin
        m_bus.word_in = tbl[acc].word;
        acc++;
      end
    end
    chkn("abort_point_reached", sh, 3 * BPW + 3);
    chk1("abort_pre_shift_en", cfg_shift_en, 1'b1);
    rst_m = 1'b0;
    @(negedge clk);
    chk1("abort_cfg_data", cfg_data, 1'b0);
    chk1("abort_shift_en", cfg_shift_en, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_ready", m_bus.word_ready, 1'b0);
    rst_m = 1'b1;
    @(negedge clk);
    chk1("abort_stays_idle", busy, 1'b0);
    chk1("abort_ready_idle", m_bus.word_ready, 1'b0);

    run_load(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
